// File: rtl/smalldiv_lut.sv
// One digit stage of a small constant divider: {last_remainder, dividend_digit} / DIVIDER_VALUE
// resolved through an elaboration-time lookup table, with an optional output register.
module smalldiv_lut #(
  parameter int DIGIT_WIDTH   = 3,
  parameter int DIVIDER_VALUE = 5,
  parameter int DIVIDER_WIDTH = $clog2(DIVIDER_VALUE),
  parameter bit REGISTER_OUT  = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [DIGIT_WIDTH-1:0]   dividend_digit,
  input  logic [DIVIDER_WIDTH-1:0] last_remainder,
  output logic [DIGIT_WIDTH-1:0]   quotient,
  output logic [DIVIDER_WIDTH-1:0] remainder,
  output logic                     invalid
);

  localparam int AW    = DIGIT_WIDTH + DIVIDER_WIDTH;
  localparam int DEPTH = 1 << AW;

  if (DIVIDER_VALUE <= 1) begin : g_chk_value
    $fatal(1, "smalldiv_lut: DIVIDER_VALUE must be >= 2");
  end
  if (DIVIDER_WIDTH < $clog2(DIVIDER_VALUE)) begin : g_chk_width
    $fatal(1, "smalldiv_lut: DIVIDER_WIDTH must be >= $clog2(DIVIDER_VALUE)");
  end
  if (DIGIT_WIDTH < 1) begin : g_chk_digit
    $fatal(1, "smalldiv_lut: DIGIT_WIDTH must be >= 1");
  end

  logic [DIGIT_WIDTH-1:0]   q_tab [DEPTH];
  logic [DIVIDER_WIDTH-1:0] r_tab [DEPTH];
  logic [AW-1:0]            idx;
  logic [DIGIT_WIDTH-1:0]   q_lut;
  logic [DIVIDER_WIDTH-1:0] r_lut;
  logic                     inv_lut;

  // Quotient entries keep only the low DIGIT_WIDTH bits; overflow is only possible when invalid.
  for (genvar n = 0; n < DEPTH; n++) begin : g_tab
    assign q_tab[n] = DIGIT_WIDTH'(n / DIVIDER_VALUE);
    assign r_tab[n] = DIVIDER_WIDTH'(n % DIVIDER_VALUE);
  end

  assign idx     = {last_remainder, dividend_digit};
  assign q_lut   = q_tab[idx];
  assign r_lut   = r_tab[idx];
  assign inv_lut = (32'(last_remainder) >= 32'(DIVIDER_VALUE));

  if (REGISTER_OUT) begin : g_reg
    logic [DIGIT_WIDTH-1:0]   quotient_q, quotient_d;
    logic [DIVIDER_WIDTH-1:0] remainder_q, remainder_d;
    logic                     invalid_q, invalid_d;

    always_comb begin
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      invalid_d   = invalid_q;
      if (enable) begin
        quotient_d  = q_lut;
        remainder_d = r_lut;
        invalid_d   = inv_lut;
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        quotient_q  <= '0;
        remainder_q <= '0;
        invalid_q   <= 1'b0;
      end else begin
        quotient_q  <= quotient_d;
        remainder_q <= remainder_d;
        invalid_q   <= invalid_d;
      end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign invalid   = invalid_q;
  end else begin : g_comb
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clock, reset, enable};

    assign quotient  = q_lut;
    assign remainder = r_lut;
    assign invalid   = inv_lut;
  end

endmodule

// File: tb/tb_smalldiv_lut.sv
// Directed bench for smalldiv_lut: registered default stage, a combinational sweep,
// and a three-stage radix-4 chain dividing by 3.
module tb_smalldiv_lut;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] dd, lr;
  logic [2:0] q, r;
  logic       inv;

  logic       c_rst, c_en;
  logic [2:0] c_dd, c_lr;
  logic [2:0] c_q, c_r;
  logic       c_inv;

  logic [5:0] ch_dividend;
  logic [1:0] ch_q2, ch_q1, ch_q0;
  logic [1:0] ch_r2, ch_r1, ch_r0;
  logic       ch_i2, ch_i1, ch_i0;

  int unsigned nchk = 0;
  int unsigned nbad = 0;

  always #5 clock = ~clock;

  smalldiv_lut #(.DIGIT_WIDTH(3), .DIVIDER_VALUE(5), .DIVIDER_WIDTH(3), .REGISTER_OUT(1'b1)) u_reg (
    .clock(clock), .reset(reset), .enable(enable), .dividend_digit(dd), .last_remainder(lr),
    .quotient(q), .remainder(r), .invalid(inv));

  smalldiv_lut #(.DIGIT_WIDTH(3), .DIVIDER_VALUE(5), .DIVIDER_WIDTH(3), .REGISTER_OUT(1'b0)) u_comb (
    .clock(clock), .reset(c_rst), .enable(c_en), .dividend_digit(c_dd), .last_remainder(c_lr),
    .quotient(c_q), .remainder(c_r), .invalid(c_inv));

  smalldiv_lut #(.DIGIT_WIDTH(2), .DIVIDER_VALUE(3), .DIVIDER_WIDTH(2), .REGISTER_OUT(1'b0)) u_ch2 (
    .clock(clock), .reset(c_rst), .enable(c_en), .dividend_digit(ch_dividend[5:4]), .last_remainder(2'd0),
    .quotient(ch_q2), .remainder(ch_r2), .invalid(ch_i2));

  smalldiv_lut #(.DIGIT_WIDTH(2), .DIVIDER_VALUE(3), .DIVIDER_WIDTH(2), .REGISTER_OUT(1'b0)) u_ch1 (
    .clock(clock), .reset(c_rst), .enable(c_en), .dividend_digit(ch_dividend[3:2]), .last_remainder(ch_r2),
    .quotient(ch_q1), .remainder(ch_r1), .invalid(ch_i1));

  smalldiv_lut #(.DIGIT_WIDTH(2), .DIVIDER_VALUE(3), .DIVIDER_WIDTH(2), .REGISTER_OUT(1'b0)) u_ch0 (
    .clock(clock), .reset(c_rst), .enable(c_en), .dividend_digit(ch_dividend[1:0]), .last_remainder(ch_r1),
    .quotient(ch_q0), .remainder(ch_r0), .invalid(ch_i0));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reg(input string tag, input int unsigned eq, input int unsigned er, input bit ei);
    check({tag, ".q"}, 32'(q), eq);
    check({tag, ".r"}, 32'(r), er);
    check({tag, ".inv"}, 32'(inv), 32'(ei));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; lr = 3'd4; dd = 3'd7;
    c_rst = 1'b0; c_en = 1'b0; c_lr = '0; c_dd = '0; ch_dividend = '0;

    #1;
    check_reg("rst_async", 0, 0, 1'b0);
    tick();
    check_reg("rst_held", 0, 0, 1'b0);

    @(negedge clock); reset = 1'b0; enable = 1'b0;
    tick();
    check_reg("rel_noen", 0, 0, 1'b0);

    @(negedge clock); enable = 1'b1;
    tick();
    check_reg("n39", 7, 4, 1'b0);

    @(negedge clock); lr = 3'd2; dd = 3'd3;
    tick();
    check_reg("n19", 3, 4, 1'b0);

    @(negedge clock); enable = 1'b0; lr = 3'd0; dd = 3'd4;
    tick();
    check_reg("hold", 3, 4, 1'b0);
    tick();
    check_reg("hold2", 3, 4, 1'b0);

    @(negedge clock); enable = 1'b1;
    tick();
    check_reg("n4", 0, 4, 1'b0);

    @(negedge clock); lr = 3'd5; dd = 3'd0;
    tick();
    check_reg("n40", 0, 0, 1'b1);

    @(negedge clock); lr = 3'd7; dd = 3'd7;
    tick();
    check_reg("n63", 4, 3, 1'b1);

    @(negedge clock); reset = 1'b1;
    #1;
    check_reg("rst_mid", 0, 0, 1'b0);
    @(negedge clock); reset = 1'b0; enable = 1'b0;
    tick();
    check_reg("rst_mid_rel", 0, 0, 1'b0);

    // Combinational stage: model is N/5 and N%5 with control inputs wiggling.
    for (int n = 0; n < 64; n++) begin
      c_lr = 3'(n >> 3);
      c_dd = 3'(n);
      c_rst = n[0];
      c_en = n[1];
      #1;
      check("comb.q", 32'(c_q), 32'((n / 5) & 7));
      check("comb.r", 32'(c_r), 32'(n % 5));
      check("comb.inv", 32'(c_inv), 32'((n >> 3) >= 5));
      #2;
    end

    ch_dividend = 6'd47;
    c_rst = 1'b1;
    #1;
    check("chain.q", 32'({ch_q2, ch_q1, ch_q0}), 32'd15);
    check("chain.r", 32'(ch_r0), 32'd2);
    check("chain.inv", 32'({ch_i2, ch_i1, ch_i0}), 32'd0);

    ch_dividend = 6'd63;
    #1;
    check("chain63.q", 32'({ch_q2, ch_q1, ch_q0}), 32'd21);
    check("chain63.r", 32'(ch_r0), 32'd0);

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule

// File: doc/smalldiv_lut.md
Name: smalldiv_lut

Overview:
- One digit stage of the small constant divider.
- Divides the concatenation {last_remainder, dividend_digit} by the constant DIVIDER_VALUE, producing a DIGIT_WIDTH-bit quotient digit and a DIVIDER_WIDTH-bit remainder.
- Stages chain MSB-digit first: each stage's remainder feeds the next lower stage's last_remainder; the top stage's last_remainder is tied to 0.
- Implemented as an elaboration-time lookup table with an optional output register.

Parameters:
- DIGIT_WIDTH, 3, width of the dividend digit and of the quotient digit; must be >= 1.
- DIVIDER_VALUE, 5, constant divisor; must be >= 2.
- DIVIDER_WIDTH, $clog2(DIVIDER_VALUE), width of the remainder input and output; must be >= $clog2(DIVIDER_VALUE).
- REGISTER_OUT, 1: 1 = outputs registered, 0 = outputs purely combinational.

Ports:
- clock  input  1  single clock; rising edge active.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  output-register load enable.
- dividend_digit  input  DIGIT_WIDTH  current dividend digit.
- last_remainder  input  DIVIDER_WIDTH  remainder from the next more-significant stage.
- quotient  output  DIGIT_WIDTH  quotient digit.
- remainder  output  DIVIDER_WIDTH  remainder passed to the next less-significant stage.
- invalid  output  1  high when last_remainder >= DIVIDER_VALUE.

Interface (already decided): one clock; reset is asynchronous and active-high, ports named clock and reset.

Behaviour:
- Index N = last_remainder * 2^DIGIT_WIDTH + dividend_digit, ranging 0 .. 2^(DIGIT_WIDTH+DIVIDER_WIDTH)-1.
- Table holds one entry per N, computed at elaboration (generate loop or constant function). No runtime divider.
- Each entry: q = N / DIVIDER_VALUE, r = N % DIVIDER_VALUE.
- quotient = q truncated to its low DIGIT_WIDTH bits; remainder = r, always < DIVIDER_VALUE.
- invalid = (last_remainder >= DIVIDER_VALUE).
- Valid inputs (last_remainder < DIVIDER_VALUE) guarantee q < 2^DIGIT_WIDTH, so no truncation occurs. Truncation only happens when invalid is high.
- REGISTER_OUT=0:
  - quotient, remainder and invalid are combinational functions of the current inputs.
  - clock, reset and enable are ignored.
- REGISTER_OUT=1:
  - Latency is 1 cycle.
  - On a rising clock edge with enable=1, outputs load the table result for the current inputs.
  - With enable=0, outputs hold.
  - reset=1 forces quotient, remainder and invalid to 0 immediately, independent of clock, and holds them at 0 while asserted.
  - Reset release: the first load happens on the first rising edge with enable=1 after reset is deasserted.
  - Reset asserted mid-operation discards the held value.
- Parameter violations must be reported by an elaboration/initial-time check, which prints a message and calls $finish:
  - DIVIDER_VALUE <= 1
  - DIVIDER_WIDTH < $clog2(DIVIDER_VALUE)
  - DIGIT_WIDTH < 1
- Table depth is 2^(DIGIT_WIDTH+DIVIDER_WIDTH). Intended for small LUT widths (about 6-8 address bits total); the block itself imposes no upper limit.

Test Plan (defaults DIVIDER_VALUE=5, DIVIDER_WIDTH=3, DIGIT_WIDTH=3, REGISTER_OUT=1 unless stated):
- Reset: assert reset with arbitrary inputs, no clock edge -> quotient=0, remainder=0, invalid=0 immediately. Outputs stay 0 until the first enabled edge after release.
- Basic: enable=1, last_remainder=2, dividend_digit=3 (N=19) -> after 1 edge quotient=3, remainder=4, invalid=0. Also last_remainder=4, dividend_digit=7 (N=39) -> quotient=7, remainder=4.
- Hold: load N=19, then set enable=0 and change inputs to last_remainder=0, dividend_digit=4 -> outputs stay 3/4. Set enable=1 -> next edge gives quotient=0, remainder=4.
- Invalid: last_remainder=5, dividend_digit=0 (N=40) -> quotient=0 (8 truncated), remainder=0, invalid=1. Also last_remainder=7, dividend_digit=7 (N=63) -> quotient=4, remainder=3, invalid=1.
- Exhaustive: REGISTER_OUT=0, sweep all 64 input combinations -> outputs match a model of N/5 and N%5 in the same delta cycle; clock and reset toggling has no effect.
- Chain: three instances (DIVIDER_VALUE=3, DIVIDER_WIDTH=2, DIGIT_WIDTH=2, REGISTER_OUT=0), top last_remainder=0, dividend 6'd47 -> quotient digits form 15, final remainder 2.
